// File: rtl/button_event_pkg.sv
// Shared constants and register decode for the push-button MMIO block.
package button_event_pkg;

    localparam logic [3:0]  BTN_LEVEL_OFF   = 4'h0;
    localparam logic [3:0]  BTN_PRESS_OFF   = 4'h4;
    localparam logic [3:0]  BTN_RELEASE_OFF = 4'h8;
    localparam logic [3:0]  BTN_IRQEN_OFF   = 4'hC;
    localparam logic [31:0] BTN_MMIO_BASE   = 32'h1000_0010;

    typedef enum logic [1:0] {
        REG_LEVEL,
        REG_PRESS,
        REG_RELEASE,
        REG_IRQEN
    } btn_reg_e;

    typedef struct packed {
        logic     hit;
        btn_reg_e sel;
    } btn_decode_t;

    function automatic btn_decode_t btn_decode(input logic [3:0] addr);
        btn_decode_t d;
        d.hit = 1'b1;
        d.sel = REG_LEVEL;
        case (addr)
            BTN_LEVEL_OFF:   d.sel = REG_LEVEL;
            BTN_PRESS_OFF:   d.sel = REG_PRESS;
            BTN_RELEASE_OFF: d.sel = REG_RELEASE;
            BTN_IRQEN_OFF:   d.sel = REG_IRQEN;
            default:         d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/button_event_unit_debounce_cell.sv
// One button: two-flop synchroniser, saturating debounce counter and stable level.
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q, meta_d;
    logic             sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;

    assign flip = (sync_q != stable_q) && (cnt_q == CNT_MAX);

    always_comb begin
        meta_d   = btn_i;
        sync_d   = meta_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q == stable_q) begin
            cnt_d = '0;
        end else if (flip) begin
            stable_d = sync_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Pulses coincide with the edge that flips stable_q, so flags set on that same edge.
    assign level      = stable_q;
    assign rise_pulse = flip && sync_q;
    assign fall_pulse = flip && !sync_q;

endmodule

// File: rtl/button_event_unit.sv
// Push-button MMIO peripheral: debounced levels, sticky W1C press/release flags, IRQ mask.
module button_event_unit
    import button_event_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    input  logic               sel_i,
    input  logic [3:0]         addr_i,
    input  logic               wr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o,
    output logic [NUM_BTN-1:0] level_o,
    output logic               irq_o
);

    logic [NUM_BTN-1:0] rise, fall;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic [NUM_BTN-1:0] wbits;
    btn_decode_t        dec;
    logic               wr_en;
    logic               unused_wdata;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_cell (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .btn_i     (btn_i[g]),
            .level     (level_o[g]),
            .rise_pulse(rise[g]),
            .fall_pulse(fall[g])
        );
    end

    assign dec          = btn_decode(addr_i);
    assign wr_en        = sel_i && wr_i && dec.hit;
    assign wbits        = wdata_i[NUM_BTN-1:0];
    assign unused_wdata = ^wdata_i;

    // Clear is applied before OR-ing in new events so a same-edge event wins.
    always_comb begin
        press_d   = press_q;
        release_d = release_q;
        irq_en_d  = irq_en_q;
        if (wr_en) begin
            case (dec.sel)
                REG_PRESS:   press_d   = press_q & ~wbits;
                REG_RELEASE: release_d = release_q & ~wbits;
                REG_IRQEN:   irq_en_d  = wbits;
                default:     ;
            endcase
        end
        press_d   = press_d | rise;
        release_d = release_d | fall;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_q   <= '0;
            release_q <= '0;
            irq_en_q  <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            irq_en_q  <= irq_en_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        if (sel_i && dec.hit) begin
            case (dec.sel)
                REG_LEVEL:   rdata_o[NUM_BTN-1:0] = level_o;
                REG_PRESS:   rdata_o[NUM_BTN-1:0] = press_q;
                REG_RELEASE: rdata_o[NUM_BTN-1:0] = release_q;
                REG_IRQEN:   rdata_o[NUM_BTN-1:0] = irq_en_q;
                default:     ;
            endcase
        end
    end

    assign irq_o = |(press_q & irq_en_q);

endmodule

// File: tb/tb_button_event_unit.sv
// Directed self-checking bench for button_event_unit with DEBOUNCE_CYCLES=8.
module tb_button_event_unit;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [1:0] btn_i;
    logic       sel_i;
    logic [3:0] addr_i;
    logic       wr_i;
    logic [7:0] wdata_i;
    logic [7:0] rdata_o;
    logic [1:0] level_o;
    logic       irq_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    button_event_unit #(
        .NUM_BTN        (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .btn_i  (btn_i),
        .sel_i  (sel_i),
        .addr_i (addr_i),
        .wr_i   (wr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .level_o(level_o),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mmio_wr(input logic [3:0] a, input logic [7:0] d);
        sel_i   = 1'b1;
        wr_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick(1);
        sel_i   = 1'b0;
        wr_i    = 1'b0;
        wdata_i = '0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        sel_i  = 1'b1;
        wr_i   = 1'b0;
        addr_i = a;
        #1;
        check(tag, {24'h0, rdata_o}, {24'h0, exp});
        sel_i  = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        btn_i   = 2'b11;
        sel_i   = 1'b0;
        addr_i  = '0;
        wr_i    = 1'b0;
        wdata_i = '0;

        // Reset state with both buttons held
        tick(2);
        check("rst_level", {30'h0, level_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        check_reg("rst_press", 4'h4, 8'h00);
        check_reg("rst_release", 4'h8, 8'h00);
        check_reg("rst_irqen", 4'hC, 8'h00);

        // Held buttons: first sampled at edge 1 after release, level flips at edge 10
        rst_i = 1'b0;
        tick(9);
        check("hold_level_early", {30'h0, level_o}, 32'h0);
        check_reg("hold_press_early", 4'h4, 8'h00);
        tick(1);
        check("hold_level", {30'h0, level_o}, 32'h3);
        check_reg("hold_press", 4'h4, 8'h03);
        mmio_wr(4'h4, 8'h03);
        check_reg("hold_press_clr", 4'h4, 8'h00);
        btn_i = 2'b00;
        tick(10);
        check("hold_rel_level", {30'h0, level_o}, 32'h0);
        check_reg("hold_release", 4'h8, 8'h03);
        mmio_wr(4'h8, 8'h03);
        check_reg("hold_release_clr", 4'h8, 8'h00);

        // Clean press and release on btn0
        btn_i = 2'b01;
        tick(9);
        check("press_level_early", {30'h0, level_o}, 32'h0);
        check_reg("press_flag_early", 4'h4, 8'h00);
        tick(1);
        check("press_level", {30'h0, level_o}, 32'h1);
        check_reg("press_flag", 4'h4, 8'h01);
        btn_i = 2'b00;
        tick(9);
        check_reg("release_flag_early", 4'h8, 8'h00);
        tick(1);
        check("release_level", {30'h0, level_o}, 32'h0);
        check_reg("release_flag", 4'h8, 8'h01);
        mmio_wr(4'h4, 8'h01);
        mmio_wr(4'h8, 8'h01);

        // Bounce on btn1: 13 segments of 3 cycles, ending high
        for (int unsigned seg = 0; seg < 13; seg++) begin
            btn_i[1] = (seg % 2 == 0);
            for (int unsigned c = 0; c < 3; c++) begin
                tick(1);
                check_reg("bounce_press", 4'h4, 8'h00);
                check_reg("bounce_release", 4'h8, 8'h00);
            end
        end
        tick(6);
        check_reg("bounce_press_early", 4'h4, 8'h00);
        tick(1);
        check_reg("bounce_press", 4'h4, 8'h02);
        check("bounce_level", {30'h0, level_o}, 32'h2);
        btn_i = 2'b00;
        tick(10);
        mmio_wr(4'h4, 8'h03);
        mmio_wr(4'h8, 8'h03);
        check_reg("bounce_cleanup", 4'h4, 8'h00);

        // W1C on the same edge the press flag sets: event wins
        btn_i = 2'b01;
        tick(9);
        mmio_wr(4'h4, 8'h01);
        check_reg("race_press", 4'h4, 8'h01);
        mmio_wr(4'h4, 8'h01);
        check_reg("race_press_clr", 4'h4, 8'h00);
        btn_i = 2'b00;
        tick(10);
        mmio_wr(4'h8, 8'h01);

        // IRQ masking
        mmio_wr(4'hC, 8'h02);
        btn_i = 2'b01;
        tick(10);
        check_reg("irq_press0", 4'h4, 8'h01);
        check("irq_masked", {31'h0, irq_o}, 32'h0);
        btn_i = 2'b11;
        tick(10);
        check_reg("irq_press01", 4'h4, 8'h03);
        check("irq_set", {31'h0, irq_o}, 32'h1);
        mmio_wr(4'h4, 8'h02);
        check("irq_clr", {31'h0, irq_o}, 32'h0);

        // Register map and ignored writes
        check_reg("map_level", 4'h0, 8'h03);
        check_reg("map_press", 4'h4, 8'h01);
        check_reg("map_release", 4'h8, 8'h00);
        check_reg("map_irqen", 4'hC, 8'h02);
        check_reg("map_hole", 4'h6, 8'h00);
        addr_i = 4'h4;
        sel_i  = 1'b0;
        #1;
        check("map_nosel", {24'h0, rdata_o}, 32'h0);
        mmio_wr(4'h6, 8'hFF);
        mmio_wr(4'h0, 8'hFF);
        check_reg("hole_wr_irqen", 4'hC, 8'h02);
        check_reg("level_wr_press", 4'h4, 8'h01);
        check("level_wr_level", {30'h0, level_o}, 32'h3);
        mmio_wr(4'hC, 8'hFF);
        check_reg("irqen_upper", 4'hC, 8'h03);
        check("irq_en0", {31'h0, irq_o}, 32'h1);

        // Reset asserted mid-count
        btn_i = 2'b00;
        tick(4);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        check("midrst_level", {30'h0, level_o}, 32'h0);
        check("midrst_irq", {31'h0, irq_o}, 32'h0);
        check_reg("midrst_press", 4'h4, 8'h00);
        check_reg("midrst_irqen", 4'hC, 8'h00);
        tick(12);
        check_reg("midrst_release", 4'h8, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
